// File: rtl/brief_sched_pkg.sv
// Shared types and widths for the BRIEF keypoint scheduler.
// Optional statistics are enabled with the BRIEF_SCHED_STATS_EN macro.
package brief_sched_pkg;

    localparam int COORD_W = 10;
    localparam int DESC_W  = 256;
    localparam int SCORE_W = 8;
    localparam int DEPTH_W = 16;
    localparam int TRIG_W  = 12;
    localparam int DROP_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0]       x;
        logic [COORD_W-1:0]       y;
        logic [SCORE_W-1:0]       score;
        logic [DEPTH_W-1:0]       depth;
        logic signed [TRIG_W-1:0] sin;
        logic signed [TRIG_W-1:0] cos;
    } kp_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [DESC_W-1:0]  desc;
        logic [SCORE_W-1:0] score;
        logic [DEPTH_W-1:0] depth;
    } desc_t;

    // True when the raster scan position (bx,by) has moved beyond (hx,hy).
    function automatic logic is_past(input logic [COORD_W-1:0] bx,
                                     input logic [COORD_W-1:0] by,
                                     input logic [COORD_W-1:0] hx,
                                     input logic [COORD_W-1:0] hy);
        return (by > hy) || ((by == hy) && (bx > hx));
    endfunction

endpackage

// File: rtl/brief_sched_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; push when full and pop when empty are ignored.
// Flush clears the pointers and wins over a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_count = wr_ptr_q - rd_ptr_q;
    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset; reads are only meaningful while non-empty.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/brief_sched.sv
// Keypoint scheduler: queues keypoints until the line buffer reaches them, then dispatches
// them to the descriptor unit under output-FIFO credit. BRIEF_SCHED_STATS_EN enables o_drop_cnt.
module brief_sched
    import brief_sched_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int ODEPTH = 4,
    parameter int LAT    = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_frame_start,
    input  logic                      i_kp_valid,
    output logic                      o_kp_ready,
    input  logic [COORD_W-1:0]        i_kp_x,
    input  logic [COORD_W-1:0]        i_kp_y,
    input  logic [SCORE_W-1:0]        i_kp_score,
    input  logic [DEPTH_W-1:0]        i_kp_depth,
    input  logic signed [TRIG_W-1:0]  i_kp_sin,
    input  logic signed [TRIG_W-1:0]  i_kp_cos,
    input  logic                      i_buf_valid,
    input  logic [COORD_W-1:0]        i_buf_x,
    input  logic [COORD_W-1:0]        i_buf_y,
    output logic [COORD_W-1:0]        o_cur_x,
    output logic [COORD_W-1:0]        o_cur_y,
    output logic [SCORE_W-1:0]        o_cur_score,
    output logic [DEPTH_W-1:0]        o_cur_depth,
    output logic signed [TRIG_W-1:0]  o_cur_sin,
    output logic signed [TRIG_W-1:0]  o_cur_cos,
    input  logic                      i_res_flag,
    input  logic [COORD_W-1:0]        i_res_x,
    input  logic [COORD_W-1:0]        i_res_y,
    input  logic [DESC_W-1:0]         i_res_desc,
    input  logic [SCORE_W-1:0]        i_res_score,
    input  logic [DEPTH_W-1:0]        i_res_depth,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [COORD_W-1:0]        o_x,
    output logic [COORD_W-1:0]        o_y,
    output logic [DESC_W-1:0]         o_desc,
    output logic [SCORE_W-1:0]        o_score,
    output logic [DEPTH_W-1:0]        o_depth,
    output logic [DROP_W-1:0]         o_drop_cnt,
    output logic                      o_busy
);

    // In-flight counter sized for whichever bound on outstanding results is larger.
    localparam int IF_MAX = (ODEPTH > LAT) ? ODEPTH : LAT;
    localparam int IFW    = $clog2(IF_MAX + 1);
    localparam int QCW    = $clog2(QDEPTH) + 1;
    localparam int OCW    = $clog2(ODEPTH) + 1;
    localparam logic [IFW-1:0] IF_ONE = IFW'(1);
    localparam logic [QCW-1:0] QC_ONE = QCW'(1);

    state_t           state_q, state_d;
    logic [IFW-1:0]   in_flight_q, in_flight_d;

    kp_t              kp_in, q_head, cur;
    logic             q_full, q_empty, q_push, q_pop;
    logic [QCW-1:0]   q_count;

    desc_t            res_in, out_head, out_vis;
    logic             out_full, out_empty, out_push, out_pop;
    logic [OCW-1:0]   out_count;

    logic             hit, stale, credit, dispatch;

    assign kp_in = '{x: i_kp_x, y: i_kp_y, score: i_kp_score, depth: i_kp_depth,
                     sin: i_kp_sin, cos: i_kp_cos};
    assign res_in = '{x: i_res_x, y: i_res_y, desc: i_res_desc, score: i_res_score,
                      depth: i_res_depth};

    assign o_kp_ready = !q_full;
    // Zero coordinates are consumed but never queued; a frame start swallows any enqueue.
    assign q_push = i_kp_valid && o_kp_ready && (i_kp_x != '0) && (i_kp_y != '0) && !i_frame_start;

    assign hit   = (state_q == ST_WAIT) && i_buf_valid &&
                   (i_buf_x == q_head.x) && (i_buf_y == q_head.y);
    assign stale = (state_q == ST_WAIT) && i_buf_valid &&
                   is_past(i_buf_x, i_buf_y, q_head.x, q_head.y);
    assign credit   = !out_full && ((int'(in_flight_q) + int'(out_count)) < ODEPTH);
    assign dispatch = hit && credit;
    assign q_pop    = hit || stale;

    assign out_push = i_res_flag && (in_flight_q != '0);
    assign out_pop  = o_valid && i_ready;

    sync_fifo #(
        .WIDTH ($bits(kp_t)),
        .DEPTH (QDEPTH)
    ) u_kp_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_frame_start),
        .i_push  (q_push),
        .i_wdata (kp_in),
        .i_pop   (q_pop),
        .o_rdata (q_head),
        .o_full  (q_full),
        .o_empty (q_empty),
        .o_count (q_count)
    );

    sync_fifo #(
        .WIDTH ($bits(desc_t)),
        .DEPTH (ODEPTH)
    ) u_out_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (1'b0),
        .i_push  (out_push),
        .i_wdata (res_in),
        .i_pop   (out_pop),
        .o_rdata (out_head),
        .o_full  (out_full),
        .o_empty (out_empty),
        .o_count (out_count)
    );

    // WAIT tracks "queue non-empty" one cycle behind the enqueue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (q_push) state_d = ST_WAIT;
            ST_WAIT: if (q_pop && !q_push && (q_count == QC_ONE)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (i_frame_start) state_d = ST_IDLE;
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (dispatch && !out_push)      in_flight_d = in_flight_q + IF_ONE;
        else if (!dispatch && out_push) in_flight_d = in_flight_q - IF_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            in_flight_q <= '0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
        end
    end

    assign cur         = (state_q == ST_WAIT) ? q_head : '0;
    assign o_cur_x     = cur.x;
    assign o_cur_y     = cur.y;
    assign o_cur_score = cur.score;
    assign o_cur_depth = cur.depth;
    assign o_cur_sin   = cur.sin;
    assign o_cur_cos   = cur.cos;

    // Outputs are masked while empty so unreset storage never leaks out.
    assign o_valid = !out_empty;
    assign out_vis = o_valid ? out_head : '0;
    assign o_x     = out_vis.x;
    assign o_y     = out_vis.y;
    assign o_desc  = out_vis.desc;
    assign o_score = out_vis.score;
    assign o_depth = out_vis.depth;

    assign o_busy = !q_empty || (in_flight_q != '0) || !out_empty;

`ifdef BRIEF_SCHED_STATS_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              drop;

    always_comb begin
        drop       = (hit && !credit) || stale;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_brief_sched.sv
// Directed bench for brief_sched: each task drives one scenario and checks inline.
module tb_brief_sched;
    import brief_sched_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_frame_start = 1'b0;
    logic               i_kp_valid = 1'b0;
    logic               o_kp_ready;
    logic [9:0]         i_kp_x = '0, i_kp_y = '0;
    logic [7:0]         i_kp_score = '0;
    logic [15:0]        i_kp_depth = '0;
    logic signed [11:0] i_kp_sin = '0, i_kp_cos = '0;
    logic               i_buf_valid = 1'b0;
    logic [9:0]         i_buf_x = '0, i_buf_y = '0;
    logic [9:0]         o_cur_x, o_cur_y;
    logic [7:0]         o_cur_score;
    logic [15:0]        o_cur_depth;
    logic signed [11:0] o_cur_sin, o_cur_cos;
    logic               i_res_flag = 1'b0;
    logic [9:0]         i_res_x = '0, i_res_y = '0;
    logic [255:0]       i_res_desc = '0;
    logic [7:0]         i_res_score = '0;
    logic [15:0]        i_res_depth = '0;
    logic               o_valid;
    logic               i_ready = 1'b0;
    logic [9:0]         o_x, o_y;
    logic [255:0]       o_desc;
    logic [7:0]         o_score;
    logic [15:0]        o_depth;
    logic [15:0]        o_drop_cnt;
    logic               o_busy;

    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];

`ifdef BRIEF_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    brief_sched #(.QDEPTH(4), .ODEPTH(4), .LAT(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
        .i_kp_valid(i_kp_valid), .o_kp_ready(o_kp_ready), .i_kp_x(i_kp_x), .i_kp_y(i_kp_y),
        .i_kp_score(i_kp_score), .i_kp_depth(i_kp_depth), .i_kp_sin(i_kp_sin), .i_kp_cos(i_kp_cos),
        .i_buf_valid(i_buf_valid), .i_buf_x(i_buf_x), .i_buf_y(i_buf_y),
        .o_cur_x(o_cur_x), .o_cur_y(o_cur_y), .o_cur_score(o_cur_score), .o_cur_depth(o_cur_depth),
        .o_cur_sin(o_cur_sin), .o_cur_cos(o_cur_cos),
        .i_res_flag(i_res_flag), .i_res_x(i_res_x), .i_res_y(i_res_y), .i_res_desc(i_res_desc),
        .i_res_score(i_res_score), .i_res_depth(i_res_depth),
        .o_valid(o_valid), .i_ready(i_ready), .o_x(o_x), .o_y(o_y), .o_desc(o_desc),
        .o_score(o_score), .o_depth(o_depth), .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [255:0] mk_desc(input logic [9:0] x, input logic [9:0] y);
        return {x, y, {59{4'h5}}};
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_frame_start = 1'b0; i_kp_valid = 1'b0; i_buf_valid = 1'b0;
        i_res_flag = 1'b0; i_ready = 1'b0;
        step(); step();
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic enqueue(input logic [9:0] x, input logic [9:0] y);
        i_kp_valid = 1'b1;
        i_kp_x = x; i_kp_y = y;
        i_kp_score = x[7:0] ^ 8'h5A;
        i_kp_depth = {6'd0, y} + 16'd1000;
        i_kp_sin = -$signed({2'b00, x});
        i_kp_cos = $signed({2'b00, y});
        step();
        i_kp_valid = 1'b0;
    endtask

    task automatic send_result(input logic [9:0] x, input logic [9:0] y);
        i_res_flag = 1'b1;
        i_res_x = x; i_res_y = y;
        i_res_desc = mk_desc(x, y);
        i_res_score = x[7:0];
        i_res_depth = {6'd0, x} + 16'd7;
        step();
        i_res_flag = 1'b0;
    endtask

    task automatic set_buf(input logic [9:0] x, input logic [9:0] y);
        i_buf_valid = 1'b1; i_buf_x = x; i_buf_y = y;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_kp_valid = 1'b1; i_kp_x = 10'd5; i_kp_y = 10'd5;
        i_res_flag = 1'b1; set_buf(10'd5, 10'd5);
        step(); step();
        total++; if (o_kp_ready !== 1'b1) begin bad++; $display("FAIL rst_kp_ready got=%0d exp=1", o_kp_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", o_valid); end
        total++; if (o_cur_x !== 10'd0) begin bad++; $display("FAIL rst_cur_x got=%0d exp=0", o_cur_x); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", o_busy); end
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", o_drop_cnt); end
        total++; if (o_desc !== 256'd0) begin bad++; $display("FAIL rst_desc got=%h exp=0", o_desc); end
        i_kp_valid = 1'b0; i_res_flag = 1'b0; i_buf_valid = 1'b0;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_hit();
        do_reset();
        i_kp_valid = 1'b1; i_kp_x = 10'd100; i_kp_y = 10'd50;
        #1;
        total++; if (o_cur_x !== 10'd0) begin bad++; $display("FAIL hit_same_cycle_cur got=%0d exp=0", o_cur_x); end
        enqueue(10'd100, 10'd50);
        total++; if (o_cur_x !== 10'd100 || o_cur_y !== 10'd50) begin bad++; $display("FAIL hit_head got=%0d,%0d exp=100,50", o_cur_x, o_cur_y); end
        total++; if (o_cur_score !== 8'd62 || o_cur_depth !== 16'd1050) begin bad++; $display("FAIL hit_head_sd got=%0d,%0d exp=62,1050", o_cur_score, o_cur_depth); end
        total++; if (o_cur_sin !== -12'sd100 || o_cur_cos !== 12'sd50) begin bad++; $display("FAIL hit_head_trig got=%0d,%0d exp=-100,50", o_cur_sin, o_cur_cos); end
        set_buf(10'd100, 10'd50);
        step();
        i_buf_valid = 1'b0;
        total++; if (o_cur_x !== 10'd0) begin bad++; $display("FAIL hit_cleared got=%0d exp=0", o_cur_x); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL hit_busy_inflight got=%0d exp=1", o_busy); end
        step(); step();
        send_result(10'd100, 10'd50);
        total++; if (o_valid !== 1'b1 || o_x !== 10'd100 || o_y !== 10'd50) begin bad++; $display("FAIL hit_out got=%0d/%0d,%0d exp=1/100,50", o_valid, o_x, o_y); end
        total++; if (o_desc !== mk_desc(10'd100, 10'd50)) begin bad++; $display("FAIL hit_desc got=%h", o_desc); end
        total++; if (o_score !== 8'd100 || o_depth !== 16'd107) begin bad++; $display("FAIL hit_sd got=%0d,%0d exp=100,107", o_score, o_depth); end
        step();
        total++; if (o_valid !== 1'b1 || o_x !== 10'd100) begin bad++; $display("FAIL hit_hold got=%0d/%0d exp=1/100", o_valid, o_x); end
        i_ready = 1'b1;
        step();
        total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL hit_drained got=%0d/%0d exp=0/0", o_valid, o_busy); end
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL hit_drop got=%0d exp=0", o_drop_cnt); end
    endtask

    task automatic test_stale();
        do_reset();
        set_buf(10'd11, 10'd5);
        enqueue(10'd10, 10'd5);
        total++; if (o_cur_x !== 10'd10) begin bad++; $display("FAIL stale_head got=%0d exp=10", o_cur_x); end
        step();
        total++; if (o_cur_x !== 10'd0 || o_busy !== 1'b0) begin bad++; $display("FAIL stale_pop got=%0d/%0d exp=0/0", o_cur_x, o_busy); end
        total++; if (o_drop_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL stale_drop got=%0d exp=%0d", o_drop_cnt, STATS); end
        set_buf(10'd19, 10'd5);
        enqueue(10'd20, 10'd5);
        step();
        total++; if (o_cur_x !== 10'd20) begin bad++; $display("FAIL stale_not_yet got=%0d exp=20", o_cur_x); end
        set_buf(10'd1, 10'd6);
        step();
        i_buf_valid = 1'b0;
        total++; if (o_cur_x !== 10'd0) begin bad++; $display("FAIL stale_next_row got=%0d exp=0", o_cur_x); end
        total++; if (o_drop_cnt !== (STATS ? 16'd2 : 16'd0)) begin bad++; $display("FAIL stale_drop2 got=%0d exp=%0d", o_drop_cnt, STATS ? 2 : 0); end
    endtask

    task automatic test_credit();
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            enqueue(10'(10 + k), 10'd1);
            set_buf(10'(10 + k), 10'd1);
            step();
            i_buf_valid = 1'b0;
            step(); step();
            send_result(10'(10 + k), 10'd1);
            exp_q.push_back(10'(10 + k));
        end
        total++; if (o_valid !== 1'b1 || o_drop_cnt !== 16'd0) begin bad++; $display("FAIL credit_four got=%0d/%0d exp=1/0", o_valid, o_drop_cnt); end
        enqueue(10'd14, 10'd1);
        set_buf(10'd14, 10'd1);
        step();
        i_buf_valid = 1'b0;
        total++; if (o_cur_x !== 10'd0) begin bad++; $display("FAIL credit_popped got=%0d exp=0", o_cur_x); end
        total++; if (o_drop_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL credit_drop got=%0d exp=%0d", o_drop_cnt, STATS); end
        send_result(10'd14, 10'd1);
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            total++; if (o_valid !== 1'b1 || o_x !== e) begin bad++; $display("FAIL credit_drain got=%0d/%0d exp=1/%0d", o_valid, o_x, e); end
            step();
        end
        total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL credit_empty got=%0d/%0d exp=0/0", o_valid, o_busy); end
    endtask

    task automatic test_full_queue();
        do_reset();
        enqueue(10'd10, 10'd2);
        enqueue(10'd20, 10'd2);
        enqueue(10'd30, 10'd2);
        enqueue(10'd40, 10'd2);
        total++; if (o_kp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0d exp=0", o_kp_ready); end
        enqueue(10'd50, 10'd2);
        total++; if (o_kp_ready !== 1'b0 || o_cur_x !== 10'd10) begin bad++; $display("FAIL full_hold got=%0d/%0d exp=0/10", o_kp_ready, o_cur_x); end
        set_buf(10'd10, 10'd2);
        step();
        total++; if (o_kp_ready !== 1'b1 || o_cur_x !== 10'd20) begin bad++; $display("FAIL full_after_hit got=%0d/%0d exp=1/20", o_kp_ready, o_cur_x); end
        set_buf(10'd20, 10'd2);
        enqueue(10'd60, 10'd2);
        total++; if (o_kp_ready !== 1'b1 || o_cur_x !== 10'd30) begin bad++; $display("FAIL full_push_pop got=%0d/%0d exp=1/30", o_kp_ready, o_cur_x); end
        i_buf_valid = 1'b0;
        enqueue(10'd70, 10'd2);
        total++; if (o_kp_ready !== 1'b0) begin bad++; $display("FAIL full_again got=%0d exp=0", o_kp_ready); end
        set_buf(10'd30, 10'd2); step();
        total++; if (o_cur_x !== 10'd40) begin bad++; $display("FAIL full_order40 got=%0d exp=40", o_cur_x); end
        set_buf(10'd40, 10'd2); step();
        total++; if (o_cur_x !== 10'd60) begin bad++; $display("FAIL full_order60 got=%0d exp=60", o_cur_x); end
        set_buf(10'd60, 10'd2); step();
        i_buf_valid = 1'b0;
        total++; if (o_cur_x !== 10'd70) begin bad++; $display("FAIL full_order70 got=%0d exp=70", o_cur_x); end
        total++; if (o_drop_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL full_inflight_drop got=%0d exp=%0d", o_drop_cnt, STATS); end
    endtask

    task automatic test_frame_flush();
        do_reset();
        enqueue(10'd100, 10'd3);
        set_buf(10'd100, 10'd3); step();
        i_buf_valid = 1'b0;
        enqueue(10'd200, 10'd9);
        enqueue(10'd210, 10'd9);
        enqueue(10'd220, 10'd9);
        total++; if (o_cur_x !== 10'd200) begin bad++; $display("FAIL flush_head got=%0d exp=200", o_cur_x); end
        i_frame_start = 1'b1;
        enqueue(10'd230, 10'd9);
        i_frame_start = 1'b0;
        total++; if (o_cur_x !== 10'd0 || dut.state_q !== ST_IDLE) begin bad++; $display("FAIL flush_idle got=%0d/%0d exp=0/0", o_cur_x, dut.state_q); end
        total++; if (o_busy !== 1'b1 || o_kp_ready !== 1'b1) begin bad++; $display("FAIL flush_busy got=%0d/%0d exp=1/1", o_busy, o_kp_ready); end
        step();
        total++; if (o_cur_x !== 10'd0) begin bad++; $display("FAIL flush_lost got=%0d exp=0", o_cur_x); end
        send_result(10'd100, 10'd3);
        total++; if (o_valid !== 1'b1 || o_x !== 10'd100) begin bad++; $display("FAIL flush_result got=%0d/%0d exp=1/100", o_valid, o_x); end
        enqueue(10'd300, 10'd9);
        total++; if (o_cur_x !== 10'd300) begin bad++; $display("FAIL flush_new_head got=%0d exp=300", o_cur_x); end
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL flush_drop got=%0d exp=0", o_drop_cnt); end
    endtask

    task automatic test_zero_coord();
        do_reset();
        enqueue(10'd0, 10'd7);
        total++; if (o_cur_x !== 10'd0 || o_busy !== 1'b0 || dut.state_q !== ST_IDLE) begin bad++; $display("FAIL zero_x got=%0d/%0d exp=0/0", o_cur_x, o_busy); end
        enqueue(10'd7, 10'd0);
        total++; if (o_cur_y !== 10'd0 || o_busy !== 1'b0) begin bad++; $display("FAIL zero_y got=%0d/%0d exp=0/0", o_cur_y, o_busy); end
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL zero_drop got=%0d exp=0", o_drop_cnt); end
        enqueue(10'd1, 10'd1);
        total++; if (o_cur_x !== 10'd1 || o_cur_y !== 10'd1) begin bad++; $display("FAIL zero_min got=%0d,%0d exp=1,1", o_cur_x, o_cur_y); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enqueue(10'd5, 10'd5);
        set_buf(10'd5, 10'd5); step();
        i_buf_valid = 1'b0;
        send_result(10'd5, 10'd5);
        enqueue(10'd6, 10'd6);
        set_buf(10'd6, 10'd6); step();
        i_buf_valid = 1'b0;
        enqueue(10'd7, 10'd7);
        total++; if (o_valid !== 1'b1 || o_cur_x !== 10'd7) begin bad++; $display("FAIL mid_setup got=%0d/%0d exp=1/7", o_valid, o_cur_x); end
        #3 i_rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0 || o_x !== 10'd0 || o_cur_x !== 10'd0) begin bad++; $display("FAIL mid_rst_out got=%0d/%0d/%0d exp=0/0/0", o_valid, o_x, o_cur_x); end
        total++; if (o_kp_ready !== 1'b1 || o_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%0d/%0d exp=1/0", o_kp_ready, o_busy); end
        step();
        i_rst_n = 1'b1;
        step();
        send_result(10'd6, 10'd6);
        total++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL mid_no_emit got=%0d/%0d exp=0/0", o_valid, o_busy); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_stale();
        test_credit();
        test_full_queue();
        test_frame_flush();
        test_zero_coord();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
